// File: rtl/i2c_config_seq.sv
// i2c_config_seq: walks a {dev_addr, reg_addr, data} table and issues I2C register writes with retry.
// Define I2C_CFG_VERIFY_EN to read each register back after writing and compare it with the written data.
module i2c_config_seq #(
  parameter int LUT_DEPTH   = 16,
  parameter int WAIT_CYCLES = 25000,
  parameter int MAX_RETRY   = 3,
  parameter int DELAY_UNIT  = 1000,
  localparam int IDX_W      = $clog2(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] lut_index,
  input  logic [23:0]      lut_data,
  output logic             i2c_write_req,
  output logic             i2c_read_req,
  input  logic             i2c_write_req_ack,
  input  logic             i2c_read_req_ack,
  output logic [7:0]       i2c_slave_dev_addr,
  output logic [7:0]       i2c_slave_reg_addr,
  output logic [7:0]       i2c_write_data,
  input  logic [7:0]       i2c_read_data,
  input  logic             i2c_error,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [7:0]       err_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_CHECK  = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DELAY  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] wait_cnt;
  logic [31:0] dly_cnt;
  logic [3:0]  retry_cnt;
  logic        xfer_ack, xfer_fail, ok_ends_attempt;
  logic        retry, exhausted, advance, last_idx;

  // Handshake: a request level is held from the edge that raises it until the edge that samples its
  // ack high; it drops on that edge. i2c_error and i2c_read_data are only looked at with an ack, and
  // an ack seen while no request of that kind is pending is ignored.
  always_comb begin
    xfer_ack        = 1'b0;
    xfer_fail       = 1'b0;
    ok_ends_attempt = 1'b1;
    case (state)
      S_WRITE: begin
        xfer_ack  = i2c_write_req_ack;
        xfer_fail = i2c_error;
`ifdef I2C_CFG_VERIFY_EN
        ok_ends_attempt = 1'b0;
`endif
      end
`ifdef I2C_CFG_VERIFY_EN
      S_VERIFY: begin
        xfer_ack  = i2c_read_req_ack;
        xfer_fail = i2c_error || (i2c_read_data != i2c_write_data);
      end
`endif
      default: ;
    endcase
  end

`ifndef I2C_CFG_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^{i2c_read_req_ack, i2c_read_data};
`endif

  assign last_idx  = (lut_index == IDX_W'(LUT_DEPTH - 1));
  assign retry     = xfer_ack && xfer_fail && (retry_cnt < 4'(MAX_RETRY));
  assign exhausted = xfer_ack && xfer_fail && !(retry_cnt < 4'(MAX_RETRY));
  assign advance   = exhausted || (xfer_ack && !xfer_fail && ok_ends_attempt) ||
                     ((state == S_DELAY) && (dly_cnt <= 32'd1));

  assign busy      = (state != S_DONE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_WAIT;
      wait_cnt           <= '0;
      dly_cnt            <= '0;
      retry_cnt          <= '0;
      lut_index          <= '0;
      i2c_write_req      <= 1'b0;
      i2c_read_req       <= 1'b0;
      i2c_slave_dev_addr <= '0;
      i2c_slave_reg_addr <= '0;
      i2c_write_data     <= '0;
      error              <= 1'b0;
      err_index          <= '0;
      err_count          <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt + 32'd1 >= 32'(WAIT_CYCLES)) begin
            lut_index <= '0;
            state     <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_CHECK: begin
          if (lut_data[23:16] == 8'hFF) begin
            state <= S_DONE;
          end else if (lut_data[23:16] == 8'hFE) begin
            // A zero count still spends one cycle in S_DELAY.
            dly_cnt <= 32'(lut_data[15:0]) * 32'(DELAY_UNIT);
            state   <= S_DELAY;
          end else begin
            i2c_slave_dev_addr <= lut_data[23:16];
            i2c_slave_reg_addr <= lut_data[15:8];
            i2c_write_data     <= lut_data[7:0];
            i2c_write_req      <= 1'b1;
            state              <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (i2c_write_req_ack) begin
            i2c_write_req <= 1'b0;
`ifdef I2C_CFG_VERIFY_EN
            if (!i2c_error) begin
              i2c_read_req <= 1'b1;
              state        <= S_VERIFY;
            end
`endif
          end
        end
`ifdef I2C_CFG_VERIFY_EN
        S_VERIFY: begin
          if (i2c_read_req_ack) i2c_read_req <= 1'b0;
        end
`endif
        S_DELAY: begin
          if (dly_cnt > 32'd1) dly_cnt <= dly_cnt - 32'd1;
        end
        S_DONE: begin
          if (start) begin
            error     <= 1'b0;
            err_index <= '0;
            err_count <= '0;
            lut_index <= '0;
            retry_cnt <= '0;
            state     <= S_CHECK;
          end
        end
        default: state <= S_WAIT;
      endcase

      // Attempt outcome bookkeeping shared by the write and read-back steps.
      if (retry) begin
        retry_cnt <= retry_cnt + 4'd1;
        state     <= S_CHECK;
      end
      if (exhausted) begin
        error <= 1'b1;
        if (!error) err_index <= lut_index;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      if (advance) begin
        retry_cnt <= '0;
        if (last_idx) begin
          state <= S_DONE;
        end else begin
          lut_index <= lut_index + IDX_W'(1);
          state     <= S_CHECK;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_config_seq.sv
// Self-checking bench for i2c_config_seq: behavioural table-walk model, I2C master responder, scoreboard.
module tb_i2c_config_seq;
  localparam int LUT_DEPTH   = 8;
  localparam int WAIT_CYCLES = 20;
  localparam int MAX_RETRY   = 3;
  localparam int DELAY_UNIT  = 10;
  localparam int IDX_W       = 3;
  localparam logic [2:0] ST_WAIT  = 3'd0;
  localparam logic [2:0] ST_DELAY = 3'd4;
`ifdef I2C_CFG_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start;
  logic [IDX_W-1:0] lut_index;
  logic [23:0]      lut_data;
  logic             i2c_write_req, i2c_read_req;
  logic             i2c_write_req_ack, i2c_read_req_ack;
  logic [7:0]       i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data, i2c_read_data;
  logic             i2c_error;
  logic             busy, done, error;
  logic [IDX_W-1:0] err_index;
  logic [7:0]       err_count;
  logic [2:0]       dbg_state;

  logic [23:0]      lut_mem [LUT_DEPTH];
  int               nack_n [LUT_DEPTH];
  int               bad_rd_n [LUT_DEPTH];
  int               wr_att [LUT_DEPTH];
  int               rd_att [LUT_DEPTH];
  logic [31:0]      exp_q[$];
  int               ack_cyc_q[$];
  int               wr_cyc_q[$];
  int               cyc, checks, errors, dual_cnt, dly_res;
  logic             m_err;
  logic [IDX_W-1:0] m_err_idx, m_end;
  logic [7:0]       m_err_cnt;

  i2c_config_seq #(
    .LUT_DEPTH(LUT_DEPTH), .WAIT_CYCLES(WAIT_CYCLES),
    .MAX_RETRY(MAX_RETRY), .DELAY_UNIT(DELAY_UNIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .lut_index(lut_index), .lut_data(lut_data),
    .i2c_write_req(i2c_write_req), .i2c_read_req(i2c_read_req),
    .i2c_write_req_ack(i2c_write_req_ack), .i2c_read_req_ack(i2c_read_req_ack),
    .i2c_slave_dev_addr(i2c_slave_dev_addr), .i2c_slave_reg_addr(i2c_slave_reg_addr),
    .i2c_write_data(i2c_write_data), .i2c_read_data(i2c_read_data),
    .i2c_error(i2c_error),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index), .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign lut_data = lut_mem[lut_index];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- master responder (driver) ----------------
  initial begin
    int wl, rl;
    wl = -1; rl = -1;
    i2c_write_req_ack = 1'b0; i2c_read_req_ack = 1'b0;
    i2c_error = 1'b0; i2c_read_data = 8'h00;
    forever begin
      @(negedge clk);
      i2c_write_req_ack = 1'b0; i2c_read_req_ack = 1'b0; i2c_error = 1'b0;
      if (!i2c_write_req) wl = -1;
      else begin
        if (wl < 0) wl = $urandom_range(0, 2);
        if (wl == 0) begin
          wr_att[lut_index]++;
          i2c_write_req_ack = 1'b1;
          i2c_error = (wr_att[lut_index] <= nack_n[lut_index]);
          ack_cyc_q.push_back(cyc);
        end
        wl--;
      end
      if (!i2c_read_req) rl = -1;
      else begin
        if (rl < 0) rl = $urandom_range(0, 2);
        if (rl == 0) begin
          rd_att[lut_index]++;
          i2c_read_req_ack = 1'b1;
          i2c_read_data = (rd_att[lut_index] <= bad_rd_n[lut_index]) ?
                          (lut_mem[lut_index][7:0] ^ 8'h01) : lut_mem[lut_index][7:0];
        end
        rl--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_write_req && i2c_read_req) dual_cnt++;
      if (dbg_state == ST_DELAY) dly_res++;
      if (i2c_write_req && !prev_wr) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("wr_extra", 32'(exp_q.size()), 32'd1);
        else check("wr_txn", {8'(lut_index), i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data},
                   exp_q.pop_front());
      end
      prev_wr = i2c_write_req;
    end
  end

  // ---------------- reference model ----------------
  // Each entry fails its first nack_n (+ bad_rd_n with read-back) attempts; retries are capped.
  task automatic build_exp();
    int fails, tries;
    exp_q.delete();
    m_err = 1'b0; m_err_idx = '0; m_err_cnt = 8'd0; m_end = IDX_W'(LUT_DEPTH - 1);
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (lut_mem[i][23:16] == 8'hFF) begin
        m_end = IDX_W'(i);
        break;
      end
      if (lut_mem[i][23:16] != 8'hFE) begin
        fails = nack_n[i] + (VERIFY_ON ? bad_rd_n[i] : 0);
        tries = (fails > MAX_RETRY) ? MAX_RETRY + 1 : fails + 1;
        repeat (tries) exp_q.push_back({8'(i), lut_mem[i]});
        if (fails > MAX_RETRY) begin
          if (!m_err) m_err_idx = IDX_W'(i);
          m_err = 1'b1;
          if (m_err_cnt != 8'hFF) m_err_cnt++;
        end
      end
    end
  endtask

  task automatic clear_policy();
    for (int i = 0; i < LUT_DEPTH; i++) begin
      lut_mem[i] = 24'hFF0000; nack_n[i] = 0; bad_rd_n[i] = 0;
    end
  endtask

  task automatic clear_att();
    for (int i = 0; i < LUT_DEPTH; i++) begin
      wr_att[i] = 0; rd_att[i] = 0;
    end
  endtask

  task automatic release_timed(input string tag);
    int n;
    n = 0;
    rst = 1'b0;
    while (!i2c_write_req && n < WAIT_CYCLES + 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, WAIT_CYCLES + 1);
  endtask

  task automatic pulse_start();
    clear_att();
    build_exp();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic end_check(input string tag);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_error"}, error, m_err);
    check({tag, "_err_index"}, err_index, m_err_idx);
    check({tag, "_err_count"}, err_count, m_err_cnt);
    check({tag, "_end_index"}, lut_index, m_end);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, gap;
    checks = 0; errors = 0; dual_cnt = 0; dly_res = 0;
    rst = 1'b0; start = 1'b0;
    clear_policy();
    clear_att();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_write_req", i2c_write_req, 1'b0);
    check("rst_read_req", i2c_read_req, 1'b0);
    check("rst_state", dbg_state, ST_WAIT);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_count", err_count, 8'd0);
    check("rst_err_index", err_index, 3'd0);
    check("rst_lut_index", lut_index, 3'd0);
    check("rst_fields", {i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data}, 24'd0);

    // Two clean writes after the power-up wait.
    lut_mem[0] = 24'h720835; lut_mem[1] = 24'h7A2F00;
    build_exp();
    release_timed("first_req_latency");
    wait_done(2000);
    end_check("basic");

    // Entry 1 NACKed on every attempt; entry 2 must still be written.
    lut_mem[0] = 24'h1001AA; lut_mem[1] = 24'h2002BB; lut_mem[2] = 24'h3003CC; lut_mem[3] = 24'hFF0000;
    nack_n[1] = 99;
    pulse_start();
    wait_done(2000);
    end_check("nack");

    // Replay after the failed run: flags clear on start, no power-up wait.
    nack_n[1] = 0;
    clear_att();
    build_exp();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check("start_clears_error", error, 1'b0);
    check("start_clears_err_count", err_count, 8'd0);
    check("start_clears_err_index", err_index, 3'd0);
    while (!i2c_write_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_req_latency", n, 2);
    n = 0;
    while (!(i2c_write_req && lut_index == 3'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored_busy", busy, 1'b1);
    check("busy_start_ignored_index", 32'(lut_index != 3'd0), 32'd1);
    wait_done(2000);
    end_check("replay");

    // Delay entry of 5 ticks between two writes.
    clear_policy();
    lut_mem[0] = 24'h720102; lut_mem[1] = 24'hFE0005; lut_mem[2] = 24'h740304;
    ack_cyc_q.delete(); wr_cyc_q.delete();
    dly_res = 0;
    pulse_start();
    wait_done(2000);
    end_check("delay");
    check("delay_residency", dly_res, 5 * DELAY_UNIT);
    gap = wr_cyc_q[1] - ack_cyc_q[0] - 1;
    check("delay_gap_in_range", 32'(gap >= 5 * DELAY_UNIT && gap <= 5 * DELAY_UNIT + 2), 32'd1);

    // Reset while a write request is pending, then a full restart.
    clear_policy();
    lut_mem[0] = 24'h720835; lut_mem[1] = 24'h7A2F00;
    pulse_start();
    n = 0;
    while (!(i2c_write_req && lut_index == 3'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached", i2c_write_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_write_req", i2c_write_req, 1'b0);
    check("rst_mid_state", dbg_state, ST_WAIT);
    check("rst_mid_index", lut_index, 3'd0);
    check("rst_mid_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    clear_att();
    build_exp();
    release_timed("rst_restart_latency");
    wait_done(2000);
    end_check("rst_restart");

`ifdef I2C_CFG_VERIFY_EN
    // First read-back returns 0x34 for a write of 0x35: one retry, then advance.
    clear_policy();
    lut_mem[0] = 24'h720835;
    bad_rd_n[0] = 1;
    pulse_start();
    check("verify_writes_expected", 32'(exp_q.size()), 32'd2);
    wait_done(2000);
    end_check("verify");
`endif

    // Randomized tables and failure patterns.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        int k;
        k = (r == 0) ? 9 : $urandom_range(0, 9);
        if (i > 0 && k == 0) lut_mem[i] = 24'hFF0000;
        else if (i > 0 && k == 1) lut_mem[i] = {8'hFE, 8'h00, 8'($urandom_range(0, 3))};
        else lut_mem[i] = {8'($urandom_range(0, 253)), 8'($urandom), 8'($urandom)};
        nack_n[i]   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
        bad_rd_n[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      end
      pulse_start();
      wait_done(3000);
      end_check("rnd");
    end

    check("no_dual_req", dual_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
